// File: rtl/addsub_pkg.sv
// Shared definitions for the add/sub arbiter: FSM encoding and flag bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int NFLAGS   = 4;
   localparam int FLAG_CF  = 3;
   localparam int FLAG_OVF = 2;
   localparam int FLAG_SF  = 1;
   localparam int FLAG_ZF  = 0;

endpackage

// File: rtl/addsub.sv
// Sign-magnitude adder/subtractor computed in two's complement, with {cf, ovf, sf, zf} flags.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              sub,
   output logic [WIDTH-1:0]  sum,
   output logic [NFLAGS-1:0] flags
);

   localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
   localparam logic [WIDTH-2:0] ONE_M = (WIDTH-1)'(1);

   logic [WIDTH-1:0] a_tc;
   logic [WIDTH-1:0] b_tc;
   logic [WIDTH-1:0] b_op;
   logic [WIDTH-1:0] res;
   logic [WIDTH-2:0] mag;
   logic             cout;

   // Convert operands, add (or add inverted b plus one), convert the result back.
   // Negative zero negates to zero, so it naturally behaves as +0.
   always_comb begin
      a_tc = a[WIDTH-1] ? (~{1'b0, a[WIDTH-2:0]} + ONE_W) : {1'b0, a[WIDTH-2:0]};
      b_tc = b[WIDTH-1] ? (~{1'b0, b[WIDTH-2:0]} + ONE_W) : {1'b0, b[WIDTH-2:0]};
      b_op = sub ? ~b_tc : b_tc;
      {cout, res} = {1'b0, a_tc} + {1'b0, b_op} + {{WIDTH{1'b0}}, sub};
      mag  = res[WIDTH-1] ? (~res[WIDTH-2:0] + ONE_M) : res[WIDTH-2:0];
      sum  = {res[WIDTH-1], mag};
      flags           = '0;
      flags[FLAG_CF]  = cout ^ sub;
      flags[FLAG_OVF] = (a_tc[WIDTH-1] == b_op[WIDTH-1]) && (res[WIDTH-1] != a_tc[WIDTH-1]);
      flags[FLAG_SF]  = res[WIDTH-1];
      flags[FLAG_ZF]  = (res == '0);
   end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/sub datapath between NREQ requesters.
// Latency: accept to rsp_valid is 2 cycles; one operation in flight, 1 op per 3 cycles peak.
// Backpressure: result held in RESP until the granted requester's rsp_ready; no new grant meanwhile.
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*WIDTH-1:0]    req_a,
   input  logic [NREQ*WIDTH-1:0]    req_b,
   input  logic [NREQ-1:0]          req_sub,
   output logic [NREQ-1:0]          rsp_valid,
   input  logic [NREQ-1:0]          rsp_ready,
   output logic [WIDTH-1:0]         rsp_sum,
   output logic [NFLAGS-1:0]        rsp_flags,
   output logic [$clog2(NREQ)-1:0]  rsp_id
);

   localparam int IDW = $clog2(NREQ);

   state_t             state_q;
   state_t             state_d;
   logic [IDW-1:0]     ptr_q;
   logic [IDW-1:0]     gnt_q;
   logic [IDW-1:0]     grant_id;
   logic               grant_vld;
   logic               accept;
   logic               armed_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic               sub_q;
   logic [WIDTH-1:0]   sum_q;
   logic [NFLAGS-1:0]  flags_q;
   logic [WIDTH-1:0]   au_sum;
   logic [NFLAGS-1:0]  au_flags;

   addsub #(.WIDTH(WIDTH)) u_addsub (
      .a     (a_q),
      .b     (b_q),
      .sub   (sub_q),
      .sum   (au_sum),
      .flags (au_flags)
   );

   // Round-robin pick: first valid index starting at ptr; descending scan so the nearest wins.
   always_comb begin
      int idx;
      idx       = 0;
      grant_vld = 1'b0;
      grant_id  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % NREQ;
         if (req_valid[idx]) begin
            grant_vld = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   // armed_q keeps grants off until the first clock edge after reset release.
   assign accept = (state_q == ST_IDLE) && grant_vld && armed_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_CALC;
         ST_CALC: state_d = ST_RESP;
         ST_RESP: if (rsp_ready[gnt_q]) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs: one-hot accept in IDLE, one-hot result valid in RESP.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (accept) req_ready[grant_id] = 1'b1;
      if (state_q == ST_RESP) rsp_valid[gnt_q] = 1'b1;
   end

   // Operand capture, result registration and pointer advance on result handoff.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sub_q   <= 1'b0;
         sum_q   <= '0;
         flags_q <= '0;
      end else begin
         armed_q <= 1'b1;
         if (accept) begin
            gnt_q <= grant_id;
            a_q   <= req_a[grant_id*WIDTH +: WIDTH];
            b_q   <= req_b[grant_id*WIDTH +: WIDTH];
            sub_q <= req_sub[grant_id];
         end
         if (state_q == ST_CALC) begin
            sum_q   <= au_sum;
            flags_q <= au_flags;
         end
         if ((state_q == ST_RESP) && rsp_ready[gnt_q]) begin
            ptr_q <= (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
         end
      end
   end

   assign rsp_sum   = sum_q;
   assign rsp_flags = flags_q;
   assign rsp_id    = gnt_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter (WIDTH=8, NREQ=4) with directed vectors.
// Latency: checks accept-to-rsp_valid of 2 cycles on every operation.
// Backpressure: exercises a held RESP with rsp_ready low and a reset during CALC.
module tb_addsub_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
   logic [N*W-1:0] req_a, req_b;
   logic [W-1:0]   rsp_sum;
   logic [3:0]     rsp_flags;
   logic [1:0]     rsp_id;

   typedef struct packed {
      logic [1:0] id;
      logic [7:0] sum;
      logic [3:0] flags;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   acc_cyc  = 0;
   logic [N-1:0] prev_rdy = '0;
   logic [N-1:0] prev_vld = '0;

   addsub_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_sub   (req_sub),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_sum   (rsp_sum),
      .rsp_flags (rsp_flags),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_sub[i]      = s;
   endtask

   task automatic push_exp(input int i, input logic [7:0] s, input logic [3:0] f);
      exp_t e;
      e.id    = 2'(i);
      e.sum   = s;
      e.flags = f;
      exp_q.push_back(e);
   endtask

   // Returns #1 after a negedge at which some masked req_ready bit is high.
   task automatic wait_rdy(input logic [N-1:0] mask, input string name);
      int n = 0;
      while (((req_ready & mask) == '0) && (n < 50)) begin
         @(negedge clk); #1;
         n++;
      end
      if ((req_ready & mask) == '0) timeout(name);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0) && (n < 100)) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) timeout(name);
   endtask

   task automatic do_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [7:0] es, input logic [3:0] ef);
      @(negedge clk);
      set_op(i, a, b, s);
      push_exp(i, es, ef);
      req_valid[i] = 1'b1;
      #1;
      wait_rdy(N'(1) << i, "op_accept");
      @(negedge clk);
      req_valid[i] = 1'b0;
      drain("op_response");
   endtask

   // Monitor: one-hot/pulse accept checks, latency, and scoreboard pop on each result handoff.
   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (req_ready != '0) begin
            check("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
            check("req_ready_pulse", 32'(prev_rdy), 32'd0);
            acc_cyc = cyc;
         end
         if ((rsp_valid != '0) && (prev_vld == '0)) check("latency", 32'(cyc - acc_cyc), 32'd2);
         if ((rsp_valid & rsp_ready) != '0) begin
            if (exp_q.size() == 0) begin
               timeout("unexpected_rsp");
            end else begin
               mon_e = exp_q.pop_front();
               check("rsp_valid_bit", 32'(rsp_valid), 32'd1 << mon_e.id);
               check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
               check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
               check("rsp_flags", 32'(rsp_flags), 32'(mon_e.flags));
            end
         end
      end
      prev_rdy = req_ready;
      prev_vld = rsp_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = '1;
      req_a     = '0;
      req_b     = '0;
      req_sub   = '0;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
      check("rst_rsp_flags", 32'(rsp_flags), 32'd0);
      check("rst_rsp_id", 32'(rsp_id), 32'd0);
      repeat (2) @(negedge clk);
      req_valid = '0;
      rst_n     = 1'b1;

      // All four requesting continuously: grants 0,1,2,3,0.
      @(negedge clk);
      for (int i = 0; i < N; i++) set_op(i, 8'(i + 1), 8'h01, 1'b0);
      for (int k = 0; k < 5; k++) push_exp(k % N, 8'(k % N + 2), 4'b0000);
      req_valid = '1;
      #1;
      for (int k = 0; k < 5; k++) begin
         wait_rdy('1, "rr_accept");
         check("rr_grant_order", 32'(req_ready), 32'd1 << (k % N));
         @(negedge clk);
         if (k == 4) req_valid = '0;
         #1;
      end
      drain("rr_response");

      // Directed arithmetic vectors.
      do_op(0, 8'h05, 8'h03, 1'b0, 8'h08, 4'b0000);
      do_op(1, 8'h03, 8'h05, 1'b1, 8'h82, 4'b1010);
      do_op(2, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0110);
      do_op(2, 8'h05, 8'h85, 1'b0, 8'h00, 4'b1001);
      do_op(3, 8'h80, 8'h00, 1'b1, 8'h00, 4'b0001);
      do_op(3, 8'h83, 8'h82, 1'b0, 8'h85, 4'b1010);
      do_op(0, 8'hFF, 8'h02, 1'b1, 8'h7F, 4'b0100);

      // Result held with rsp_ready[1] low; other rsp_ready bits high, req2 waiting.
      @(negedge clk);
      rsp_ready = 4'b1101;
      set_op(1, 8'h10, 8'h20, 1'b0);
      push_exp(1, 8'h30, 4'b0000);
      req_valid[1] = 1'b1;
      #1;
      wait_rdy(4'b0010, "hold_accept");
      @(negedge clk);
      req_valid[1] = 1'b0;
      set_op(2, 8'h7F, 8'h01, 1'b0);
      push_exp(2, 8'h80, 4'b0110);
      req_valid[2] = 1'b1;
      begin
         int n = 0;
         #1;
         while (!rsp_valid[1] && (n < 20)) begin
            @(negedge clk); #1;
            n++;
         end
         if (!rsp_valid[1]) timeout("hold_rsp");
      end
      for (int k = 0; k < 5; k++) begin
         check("hold_rsp_valid", 32'(rsp_valid), 32'h2);
         check("hold_rsp_sum", 32'(rsp_sum), 32'h30);
         check("hold_req_ready", 32'(req_ready), 32'd0);
         @(negedge clk); #1;
      end
      rsp_ready = '1;
      wait_rdy(4'b0100, "hold_next_accept");
      @(negedge clk);
      req_valid[2] = 1'b0;
      drain("hold_response");

      // Reset during CALC: pointer is 3 here, so a surviving pointer would grant 3 first.
      @(negedge clk);
      set_op(0, 8'h11, 8'h22, 1'b0);
      req_valid[0] = 1'b1;
      #1;
      wait_rdy(4'b0001, "calc_accept");
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async_rsp_sum", 32'(rsp_sum), 32'd0);
      check("async_rsp_flags", 32'(rsp_flags), 32'd0);
      check("async_rsp_id", 32'(rsp_id), 32'd0);
      check("async_rsp_valid", 32'(rsp_valid), 32'd0);
      set_op(1, 8'h01, 8'h01, 1'b0);
      set_op(3, 8'h02, 8'h01, 1'b1);
      req_valid = 4'b1010;
      #1;
      check("in_reset_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(negedge clk);
      check("in_reset_rsp_valid", 32'(rsp_valid), 32'd0);
      push_exp(1, 8'h02, 4'b0000);
      push_exp(3, 8'h01, 4'b0000);
      rst_n = 1'b1;
      #1;
      wait_rdy('1, "post_reset_accept");
      check("post_reset_grant", 32'(req_ready), 32'h2);
      @(negedge clk);
      req_valid[1] = 1'b0;
      #1;
      wait_rdy(4'b1000, "post_reset_second");
      @(negedge clk);
      req_valid[3] = 1'b0;
      drain("post_reset_response");

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in sign-magnitude (MSB = sign).
REQ-002 SHALL have parameter NREQ, default 4, number of requesters sharing one add/sub datapath (2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  per-requester accept; at most one bit high.
REQ-007 SHALL have port req_a  input  NREQ*WIDTH  operand a, requester i at slice [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b  input  NREQ*WIDTH  operand b, same slicing.
REQ-009 SHALL have port req_sub  input  NREQ  1 = a-b, 0 = a+b.
REQ-010 SHALL have port rsp_valid  output  NREQ  result valid for granted requester; at most one bit high.
REQ-011 SHALL have port rsp_ready  input  NREQ  per-requester result accept.
REQ-012 SHALL have port rsp_sum  output  WIDTH  registered sign-magnitude result.
REQ-013 SHALL have port rsp_flags  output  4  registered {cf, ovf, sf, zf}.
REQ-014 SHALL have port rsp_id  output  clog2(NREQ)  index of requester owning current result.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, RESP.
REQ-016 IDLE: if any req_valid, grant g = first valid index scanning ptr, ptr+1, ... modulo NREQ; req_ready[g]=1 combinationally that cycle; capture a, b, sub, g; next CALC; else stay IDLE with req_ready=0.
REQ-017 CALC: one cycle; register addsub outputs into rsp_sum/rsp_flags; next RESP.
REQ-018 RESP: rsp_valid[g]=1, rsp_sum/rsp_flags/rsp_id stable; on rsp_ready[g]=1 return to IDLE and set ptr = (g+1) mod NREQ; else hold.
REQ-019 Latency: request accept to rsp_valid = 2 cycles; peak throughput 1 op per 3 cycles.
REQ-020 req_ready SHALL be 0 in CALC and RESP regardless of req_valid.
REQ-021 rsp_ready bits of non-granted requesters SHALL be ignored.
REQ-022 Arithmetic SHALL follow addsub unit: operands converted to two's complement, negative zero (sign set, magnitude 0) treated as +0, result converted back; a result of -0 is reported as 0x00.
REQ-023 Flags: cf = carry out (inverted for sub); ovf = two's-complement overflow; sf = result MSB; zf = result == 0.
REQ-024 Request deasserted before grant SHALL be dropped with no side effect; ptr unchanged while IDLE with no grant.

Reset
REQ-025 On rst_n=0 (any state, mid-operation included): FSM = IDLE, ptr = 0, req_ready = 0, rsp_valid = 0, rsp_sum = 0, rsp_flags = 0, rsp_id = 0; in-flight operation discarded.
REQ-026 First grant after reset release SHALL be no earlier than the first rising edge with rst_n=1.

Structure
REQ-027 FSM state encoding and flag bit positions (CF=3, OVF=2, SF=1, ZF=0) SHALL live in shared package addsub_pkg.
REQ-028 SHALL instantiate exactly one existing addsub (WIDTH) sub-module fed from captured operand registers; no second adder.

Verification (WIDTH=8, NREQ=4)
REQ-029 Req0 a=0x05 b=0x03 sub=0 -> rsp_valid[0] 2 cycles after accept, rsp_sum=0x08, flags=0000.
REQ-030 Req1 a=0x03 b=0x05 sub=1 -> rsp_sum=0x82, flags cf=1 ovf=0 sf=1 zf=0; rsp_id=1.
REQ-031 Req2 a=0x7F b=0x01 sub=0 -> rsp_sum=0x80, ovf=1 sf=1 cf=0; req2 a=0x05 b=0x85 add -> rsp_sum=0x00, zf=1 cf=1.
REQ-032 All four req_valid held high, rsp_ready high -> grant order 0,1,2,3,0; each req_ready a single-cycle pulse.
REQ-033 rsp_ready[g] held low 5 cycles in RESP -> rsp_valid/rsp_sum stable, no req_ready; rsp_ready of other index ignored.
REQ-034 rst_n pulsed low during CALC -> all outputs 0 asynchronously, ptr=0, next grant goes to lowest valid index.
